// File: rtl/mux_4to1_arbiter.sv
// rtl/mux_4to1_arbiter.sv - round-robin (or fixed-priority under MUX_ARB_FIXED_PRIO_EN) arbiter for the 4:1 ALU operand mux
module mux_4to1_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             ready,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Z,
    output logic             valid,
    output logic [3:0]       gnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       s_next;
    logic [WIDTH-1:0] z_next;
    logic [1:0]       winner;
    logic [WIDTH-1:0] win_word;

`ifndef MUX_ARB_FIXED_PRIO_EN
    logic [1:0]       last;
    logic [1:0]       last_next;
    logic [1:0]       idx;
`endif

    // Winner selection: lowest set bit, or first set bit scanning up from last+1
    always_comb begin
        winner = 2'd0;
`ifdef MUX_ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
`else
        // Scan from lowest to highest priority so the highest-priority hit is written last;
        // i == 4 lands on last itself, the lowest-priority slot.
        idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) winner = idx;
        end
`endif
    end

    // Operand mux driven by the arbitration result
    always_comb begin
        case (winner)
            2'd0:    win_word = A;
            2'd1:    win_word = B;
            2'd2:    win_word = C;
            default: win_word = D;
        endcase
    end

    // Next-state logic: capture on arbitration, release on accepted handshake
    always_comb begin
        state_next = state;
        s_next     = S;
        z_next     = Z;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_next  = last;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = HOLD;
                    s_next     = winner;
                    z_next     = win_word;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_next = IDLE;
`ifndef MUX_ARB_FIXED_PRIO_EN
                    last_next  = S;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset clears them without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            S     <= 2'b00;
            Z     <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last  <= 2'b11;
`endif
        end else begin
            state <= state_next;
            S     <= s_next;
            Z     <= z_next;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last  <= last_next;
`endif
        end
    end

    assign valid = (state == HOLD);

    // Completion strobe to the held winner; follows valid so it drops with reset
    always_comb begin
        gnt = 4'b0000;
        if (valid && ready) gnt[S] = 1'b1;
    end

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// tb/tb_mux_4to1_arbiter.sv - table-driven self-checking bench for mux_4to1_arbiter
module tb_mux_4to1_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] a, b, c, d;
    logic        ready;
    logic [1:0]  s;
    logic [31:0] z;
    logic        valid;
    logic [3:0]  gnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] a, b, c, d;
        logic        ready;
        logic        e_valid;
        logic [1:0]  e_s;
        logic [31:0] e_z;
        logic [3:0]  e_gnt;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic        c_rst, c_ready;
    logic [3:0]  c_req;
    logic [31:0] c_a, c_b, c_c, c_d;
    logic [1:0]  ps, w;
    logic [31:0] pz;

    mux_4to1_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .A     (a),
        .B     (b),
        .C     (c),
        .D     (d),
        .ready (ready),
        .S     (s),
        .Z     (z),
        .valid (valid),
        .gnt   (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic ev, input logic [1:0] es, input logic [31:0] ez,
                       input logic [3:0] eg, input string name);
        vec_t v;
        v.rst = c_rst; v.req = c_req; v.a = c_a; v.b = c_b; v.c = c_c; v.d = c_d;
        v.ready = c_ready; v.e_valid = ev; v.e_s = es; v.e_z = ez; v.e_gnt = eg;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic ev, input logic [1:0] es,
                             input logic [31:0] ez, input logic [3:0] eg);
        check({name, ".valid"}, {31'b0, valid}, {31'b0, ev});
        check({name, ".S"}, {30'b0, s}, {30'b0, es});
        check({name, ".Z"}, z, ez);
        check({name, ".gnt"}, {28'b0, gnt}, {28'b0, eg});
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; a = '0; b = '0; c = '0; d = '0; ready = 1'b0;

        // Reset held with all requesting
        c_rst = 1'b1; c_req = 4'b1111; c_a = '0; c_b = '0; c_c = '0; c_d = '0; c_ready = 1'b1;
        add(0, 0, 0, 0, "reset0");
        add(0, 0, 0, 0, "reset1");
        c_rst = 1'b0; c_req = 4'b0000; c_ready = 1'b0;
        add(0, 0, 0, 0, "idle_after_reset");

        // Single request from C
        c_req = 4'b0100; c_c = 32'hCAFE0002; c_ready = 1'b1;
        add(0, 0, 0, 0, "single_arb");
        add(1, 2, 32'hCAFE0002, 4'b0100, "single_hold");
        c_req = 4'b0000;
        add(0, 2, 32'hCAFE0002, 4'b0000, "single_done");

        // Round-robin from a fresh reset
        c_rst = 1'b1;
        add(0, 0, 0, 0, "rr_reset");
        c_rst = 1'b0; c_req = 4'b1111; c_a = 0; c_b = 1; c_c = 2; c_d = 3;
        ps = 2'd0; pz = '0;
        for (int k = 0; k < 6; k++) begin
            add(0, ps, pz, 4'b0000, "rr_arb");
`ifdef MUX_ARB_FIXED_PRIO_EN
            w = 2'd0;
`else
            w = 2'(k);
`endif
            add(1, w, {30'b0, w}, 4'b0001 << w, "rr_hold");
            ps = w; pz = {30'b0, w};
        end

        // Backpressure: A changes during the stall, held word must not
        c_req = 4'b0001; c_a = 32'h1; c_ready = 1'b0;
        add(0, ps, pz, 4'b0000, "bp_arb");
        for (int k = 0; k < 5; k++) begin
            if (k == 1) c_a = 32'h2;
            add(1, 0, 32'h1, 4'b0000, "bp_stall");
        end
        c_ready = 1'b1;
        add(1, 0, 32'h1, 4'b0001, "bp_accept");
        c_req = 4'b0000;
        add(0, 0, 32'h1, 4'b0000, "bp_gnt_once");

        // Wrap and skip: grant D, then B (A skipped), then D again
        c_req = 4'b1000; c_d = 32'hD;
        add(0, 0, 32'h1, 4'b0000, "wrap_arb_d");
        add(1, 3, 32'hD, 4'b1000, "wrap_hold_d");
        c_req = 4'b1010; c_b = 32'hB; c_d = 32'hD2;
        add(0, 3, 32'hD, 4'b0000, "wrap_arb_b");
        add(1, 1, 32'hB, 4'b0010, "wrap_hold_b");
        add(0, 1, 32'hB, 4'b0000, "wrap_arb_next");
`ifdef MUX_ARB_FIXED_PRIO_EN
        add(1, 1, 32'hB, 4'b0010, "wrap_hold_next");
        ps = 2'd1; pz = 32'hB;
`else
        add(1, 3, 32'hD2, 4'b1000, "wrap_hold_next");
        ps = 2'd3; pz = 32'hD2;
`endif
        c_req = 4'b0000;
        add(0, ps, pz, 4'b0000, "wrap_done");

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req; ready = vecs[i].ready;
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            #1;
            check_all($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].e_valid,
                      vecs[i].e_s, vecs[i].e_z, vecs[i].e_gnt);
        end

        // Reset mid-HOLD: valid and gnt drop without a clock edge
        @(negedge clk);
        req = 4'b1000; d = 32'hDEAD; ready = 1'b0;
        @(negedge clk);
        check_all("midrst_hold", 1'b1, 2'd3, 32'hDEAD, 4'b0000);
        ready = 1'b1;
        #1;
        check("midrst_gnt_before", {28'b0, gnt}, 32'h8);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid_async", {31'b0, valid}, 32'h0);
        check("midrst_gnt_async", {28'b0, gnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1001; a = 32'hA0; d = 32'hD0; ready = 1'b1;
        @(negedge clk);
        check_all("midrst_first_a", 1'b1, 2'd0, 32'hA0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_4to1_arbiter.md
# mux_4to1_arbiter

Round-robin arbiter and sequencer for the shared 32-bit 4:1 operand mux feeding the ALU. Four requesters (A–D) each present a word and a request. The block selects one requester and drives the mux select. It captures the selected word into an output register and holds it under a valid/ready handshake until the ALU side accepts it. It then returns a one-cycle grant to the winning requester.

## Interface
- `WIDTH`, 32, data width of each source and of `Z`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  4  request per source; bit 0 = A, 1 = B, 2 = C, 3 = D
- `A`, `B`, `C`, `D`  in  WIDTH each  source words
- `ready`  in  1  downstream accepts `Z` this cycle
- `S`  out  2  registered select / index of current winner (0=A…3=D)
- `Z`  out  WIDTH  registered selected word
- `valid`  out  1  `Z` holds an unaccepted word
- `gnt`  out  4  one-hot completion strobe, combinational: `gnt[S] = valid & ready`

## Operation
- Two-state FSM: IDLE, HOLD.
- IDLE, `req == 0`: stay; outputs unchanged, `valid = 0`.
- IDLE, `req != 0`:
  - Pick the winner by priority order starting at `last+1` (mod 4), scanning upward with wrap.
  - At the edge: `S <= winner`, `Z <=` winner's word (A/B/C/D per index), `valid <= 1`, go to HOLD.
- HOLD: `S`, `Z`, `valid` frozen; changes on `A`–`D` and `req` are ignored.
- HOLD with `valid & ready`:
  - `gnt[S]` is high this cycle.
  - At the edge: `last <= S`, `valid <= 0`, go to IDLE.
- HOLD without `ready`: stay indefinitely; no timeout.
- `last` is a 2-bit pointer and wraps 3→0.
- Requester protocol:
  - Hold `req` and data until its `gnt` bit pulses.
  - Deassert `req` on the edge following `gnt`, unless it has another word.
  - A requester that keeps `req` high is re-eligible, but at lowest priority.
- `gnt` is never asserted outside HOLD.
- At most one `gnt` bit is ever high.

## Timing
- Reset values: state IDLE, `valid = 0`, `S = 2'b00`, `Z = 0`, `last = 2'b11` (first priority A), `gnt = 0`.
- Request-to-valid latency: 1 cycle. A `req` sampled high at edge N gives `valid` high after edge N.
- Handshake completes at the first edge where `valid & ready`.
- `ready` may be high before `valid`; it has no effect in IDLE.
- Maximum throughput: one word per 2 cycles (arbitrate, accept).
- With all four requesting continuously and `ready = 1`, the grant order is A, B, C, D, A…
- `rst` asserted mid-HOLD:
  - `valid` and `gnt` drop immediately, without waiting for a clock.
  - The held word is discarded and `last` returns to 3.
- `rst` deassertion takes effect at the next rising edge.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority A > B > C > D.
  - `last` is not implemented; the winner is the lowest set `req` bit.
  - A continuously requesting A starves all others.
- Undefined (default): round-robin as described above.
- The interface is identical in both builds.

## Test plan
- **Reset:** assert `rst` with `req = 4'b1111`.
  - Required: `valid = 0`, `S = 0`, `Z = 0`, `gnt = 0` throughout.
- **Single request:** `req = 4'b0100`, `C = 32'hCAFE0002`, `ready = 1`.
  - Required: one cycle later `valid = 1`, `S = 2`, `Z = 32'hCAFE0002`, and `gnt = 4'b0100` in that same cycle.
  - The next cycle: `valid = 0`.
- **Round-robin:** `req = 4'b1111` held; sources A–D = 0, 1, 2, 3; `ready = 1`.
  - Required: accepted `Z` sequence 0, 1, 2, 3, 0, 1 on every second cycle.
  - Under `MUX_ARB_FIXED_PRIO_EN`: the sequence is all 0.
- **Backpressure:** `req = 4'b0001`, `ready = 0` for 5 cycles; change `A` from `32'h1` to `32'h2` during the stall.
  - Required: `Z` stays `32'h1`, `gnt = 0`.
  - When `ready` rises: `gnt = 4'b0001` for one cycle only.
- **Wrap and skip:** after a grant to D, present `req = 4'b1010`.
  - Required: B is granted next (index 0 has no request, so it is skipped), then D.
- **Reset mid-HOLD:** `valid = 1`, `S = 3`; pulse `rst` asynchronously.
  - Required: `valid` and `gnt` fall without a clock.
  - After release with `req = 4'b1001`: A is granted first.
